// File: rtl/debug_display_scanner.sv
// Debug front end for the register-file display port: two debounced buttons step the
// register index, and the sampled register value is scanned out as hex on a common-anode display.
module debug_display_scanner #(
  parameter int p_data_width      = 16,
  parameter int p_address_width   = 3,
  parameter int p_digit_period    = 50000,
  parameter int p_debounce_cycles = 500000
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_btn_next,
  input  logic                       i_w_btn_prev,
  input  logic [p_data_width-1:0]    i_w_disp_data,
  output logic [p_address_width-1:0] o_w_disp_address,
  output logic [p_address_width-1:0] o_w_leds,
  output logic [p_data_width/4-1:0]  o_r_anode,
  output logic [6:0]                 o_r_segments
);

  localparam int lp_digits = p_data_width / 4;
  localparam int lp_pc_w   = $clog2(p_digit_period);
  localparam int lp_dig_w  = (lp_digits > 1) ? $clog2(lp_digits) : 1;
  localparam int lp_db_w   = $clog2(p_debounce_cycles);

  localparam logic [lp_pc_w-1:0]  lp_period_last = lp_pc_w'(p_digit_period - 1);
  localparam logic [lp_dig_w-1:0] lp_digit_last  = lp_dig_w'(lp_digits - 1);
  localparam logic [lp_db_w-1:0]  lp_db_last     = lp_db_w'(p_debounce_cycles - 1);

  function automatic logic [6:0] f_hex_segments(input logic [3:0] i_nibble);
    case (i_nibble)
      4'h0: f_hex_segments = 7'b1000000;
      4'h1: f_hex_segments = 7'b1111001;
      4'h2: f_hex_segments = 7'b0100100;
      4'h3: f_hex_segments = 7'b0110000;
      4'h4: f_hex_segments = 7'b0011001;
      4'h5: f_hex_segments = 7'b0010010;
      4'h6: f_hex_segments = 7'b0000010;
      4'h7: f_hex_segments = 7'b1111000;
      4'h8: f_hex_segments = 7'b0000000;
      4'h9: f_hex_segments = 7'b0010000;
      4'hA: f_hex_segments = 7'b0001000;
      4'hB: f_hex_segments = 7'b0000011;
      4'hC: f_hex_segments = 7'b1000110;
      4'hD: f_hex_segments = 7'b0100001;
      4'hE: f_hex_segments = 7'b0000110;
      default: f_hex_segments = 7'b0001110;
    endcase
  endfunction

  // Button bit 0 = next, bit 1 = prev
  logic [1:0]               r_sync_a;
  logic [1:0]               r_sync_b;
  logic [1:0]               r_deb;
  logic [lp_db_w-1:0]       r_db_cnt [0:1];
  logic [1:0]               w_accept;
  logic [1:0]               w_press;

  logic [p_address_width-1:0] r_index;
  logic [lp_pc_w-1:0]         r_period;
  logic [lp_dig_w-1:0]        r_digit;
  logic [p_data_width-1:0]    r_snapshot;
  logic                       r_load;

  logic                       w_period_last;
  logic                       w_digit_last;
  logic [3:0]                 w_nibble;
  logic [lp_digits-1:0]       w_onehot;

  // Accepting a new debounced level of 1 is exactly the 0->1 press event
  always_comb begin
    w_accept = '0;
    w_press  = '0;
    for (int b = 0; b < 2; b++) begin
      w_accept[b] = (r_sync_b[b] != r_deb[b]) && (r_db_cnt[b] == lp_db_last);
      w_press[b]  = w_accept[b] && r_sync_b[b];
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_sync_a    <= '0;
      r_sync_b    <= '0;
      r_deb       <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync_a <= {i_w_btn_prev, i_w_btn_next};
      r_sync_b <= r_sync_a;
      for (int b = 0; b < 2; b++) begin
        if (r_sync_b[b] == r_deb[b]) begin
          r_db_cnt[b] <= '0;
        end else if (w_accept[b]) begin
          r_deb[b]    <= r_sync_b[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + lp_db_w'(1);
        end
      end
    end
  end

  // Power-of-two register count makes the wrap a natural overflow
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_index <= '0;
    end else if (w_press[0] && !w_press[1]) begin
      r_index <= r_index + p_address_width'(1);
    end else if (w_press[1] && !w_press[0]) begin
      r_index <= r_index - p_address_width'(1);
    end
  end

  assign o_w_disp_address = r_index;
  assign o_w_leds         = r_index;

  assign w_period_last = (r_period == lp_period_last);
  assign w_digit_last  = (r_digit == lp_digit_last);
  assign w_nibble      = r_snapshot[4*r_digit +: 4];
  assign w_onehot      = lp_digits'(1) << r_digit;

  // Snapshot only reloads at a scan wrap so one scan never mixes two register values
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_period     <= '0;
      r_digit      <= '0;
      r_snapshot   <= '0;
      r_load       <= 1'b1;
      o_r_anode    <= '1;
      o_r_segments <= '1;
    end else begin
      r_period <= w_period_last ? '0 : r_period + lp_pc_w'(1);
      if (w_period_last) begin
        r_digit <= w_digit_last ? '0 : r_digit + lp_dig_w'(1);
      end
      if (r_load || (w_period_last && w_digit_last)) begin
        r_snapshot <= i_w_disp_data;
      end
      r_load       <= 1'b0;
      o_r_anode    <= ~w_onehot;
      o_r_segments <= f_hex_segments(w_nibble);
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Scoreboard bench for debug_display_scanner: stimulus queues expected display and
// address events, independent monitors pop and compare when the DUT outputs change.
module tb_debug_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [15:0] disp_data = 16'h1A2F;
  logic [2:0]  disp_address;
  logic [2:0]  leds;
  logic [3:0]  anode;
  logic [6:0]  segments;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         gap;
  } disp_t;

  disp_t      q_disp[$];
  logic [2:0] q_addr[$];

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_F = 7'b0001110;

  debug_display_scanner #(
    .p_data_width(16),
    .p_address_width(3),
    .p_digit_period(4),
    .p_debounce_cycles(3)
  ) dut (
    .i_w_clk(clk),
    .i_w_reset(rst),
    .i_w_btn_next(btn_next),
    .i_w_btn_prev(btn_prev),
    .i_w_disp_data(disp_data),
    .o_w_disp_address(disp_address),
    .o_w_leds(leds),
    .o_r_anode(anode),
    .o_r_segments(segments)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Display monitor: every change of the lit digit/segments pops one expectation
  logic [10:0] prev_disp = 11'h7ff;
  int          last_cyc = 0;
  always @(negedge clk) begin
    disp_t e;
    int    gap;
    if ({anode, segments} != prev_disp) begin
      gap       = cyc - last_cyc;
      last_cyc  = cyc;
      prev_disp = {anode, segments};
      if (q_disp.size() > 0) begin
        e = q_disp.pop_front();
        checks++;
        if (anode !== e.an || segments !== e.seg || (e.gap >= 0 && gap != e.gap)) begin
          errors++;
          $display("FAIL display: got anode=%b seg=%b gap=%0d, want anode=%b seg=%b gap=%0d",
                   anode, segments, gap, e.an, e.seg, e.gap);
        end
      end
    end
  end

  // Address monitor: any address change must have been predicted
  logic [2:0] prev_addr = 3'd0;
  always @(negedge clk) begin
    logic [2:0] e;
    if (disp_address !== prev_addr) begin
      prev_addr = disp_address;
      checks++;
      if (q_addr.size() == 0) begin
        errors++;
        $display("FAIL address_unexpected: got %0d, want no change", disp_address);
      end else begin
        e = q_addr.pop_front();
        if (disp_address !== e || leds !== e) begin
          errors++;
          $display("FAIL address: got addr=%0d leds=%0d, want %0d", disp_address, leds, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_disp(input logic [3:0] an, input logic [6:0] seg, input int gap);
    disp_t e;
    e.an = an;
    e.seg = seg;
    e.gap = gap;
    q_disp.push_back(e);
  endtask

  task automatic wait_anode(input logic [3:0] v, input int max_cyc);
    bit hit = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (anode === v) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_anode: got %b, want %b within %0d cycles", anode, v, max_cyc);
    end
  endtask

  task automatic wait_disp_drained(input int max_cyc);
    for (int i = 0; i < max_cyc && q_disp.size() > 0; i++) @(negedge clk);
    chk("display_queue_drained", 16'(q_disp.size()), 16'd0);
  endtask

  task automatic press(input bit nxt, input bit prv, input int hold);
    @(negedge clk);
    btn_next = nxt;
    btn_prev = prv;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_anode", 16'(anode), 16'hF);
    chk("reset_segments", 16'(segments), 16'h7F);
    chk("reset_address", 16'(disp_address), 16'd0);
    chk("reset_leds", 16'(leds), 16'd0);

    // First edge shows the stale zero snapshot, then F,2,A,1 with 4-cycle digits
    push_disp(4'b1110, SEG_0, -1);
    push_disp(4'b1110, SEG_F, 1);
    push_disp(4'b1101, SEG_2, 3);
    push_disp(4'b1011, SEG_A, 4);
    push_disp(4'b0111, SEG_1, 4);
    rst = 1'b0;
    wait_disp_drained(40);

    // Held press gives one step; glitch and release give none
    q_addr.push_back(3'd1);
    press(1'b1, 1'b0, 10);
    @(negedge clk);
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    chk("after_glitch_address", 16'(disp_address), 16'd1);

    // Wrap up through 7 to 0, then down to 7
    for (int k = 2; k <= 8; k++) begin
      q_addr.push_back(3'(k));
      press(1'b1, 1'b0, 8);
    end
    q_addr.push_back(3'd7);
    press(1'b0, 1'b1, 8);
    press(1'b1, 1'b1, 8);
    chk("both_pressed_address", 16'(disp_address), 16'd7);

    // Tear-free: data changes while digit 1 of a 1111 scan is lit
    disp_data = 16'h1111;
    wait_anode(4'b0111, 40);
    wait_anode(4'b1110, 40);
    wait_anode(4'b1101, 40);
    #1;
    push_disp(4'b1011, SEG_1, 4);
    push_disp(4'b0111, SEG_1, 4);
    push_disp(4'b1110, SEG_2, 4);
    push_disp(4'b1101, SEG_2, 4);
    push_disp(4'b1011, SEG_2, 4);
    push_disp(4'b0111, SEG_2, 4);
    disp_data = 16'h2222;
    wait_disp_drained(60);

    // Async reset mid-scan with address 5 and digit 2 lit
    q_addr.push_back(3'd6);
    press(1'b0, 1'b1, 8);
    q_addr.push_back(3'd5);
    press(1'b0, 1'b1, 8);
    wait_anode(4'b1011, 40);
    q_addr.push_back(3'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_anode", 16'(anode), 16'hF);
    chk("async_reset_segments", 16'(segments), 16'h7F);
    chk("async_reset_address", 16'(disp_address), 16'd0);
    chk("async_reset_leds", 16'(leds), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    chk("address_queue_drained", 16'(q_addr.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
